// File: rtl/multi_watermark_counter_if.sv
// Bundle of control, data and status signals for the multi-channel watermark counter.
// The master side drives commands and observes counters; the slave side is the counter bank.
interface multi_watermark_counter_if #(
  parameter int NUM_CHAN = 4,
  parameter int WIDTH    = 8
);
  logic                               clr_i;
  logic [NUM_CHAN-1:0]                clear_i;
  logic [NUM_CHAN-1:0]                clear_wm_i;
  logic [NUM_CHAN-1:0]                en_i;
  logic [NUM_CHAN-1:0]                load_i;
  logic [NUM_CHAN-1:0]                down_i;
  logic [NUM_CHAN-1:0][WIDTH-1:0]     delta_i;
  logic [NUM_CHAN-1:0][WIDTH-1:0]     d_i;
  logic [WIDTH-1:0]                   thresh_i;

  logic [NUM_CHAN-1:0][WIDTH-1:0]     q_o;
  logic [NUM_CHAN-1:0][WIDTH-1:0]     max_o;
  logic [NUM_CHAN-1:0][WIDTH-1:0]     min_o;
  logic [NUM_CHAN-1:0]                wrap_o;
  logic [NUM_CHAN-1:0]                wm_wrap_o;
  logic [NUM_CHAN-1:0]                alarm_o;

  modport master (
    output clr_i, clear_i, clear_wm_i, en_i, load_i, down_i, delta_i, d_i, thresh_i,
    input  q_o, max_o, min_o, wrap_o, wm_wrap_o, alarm_o
  );

  modport slave (
    input  clr_i, clear_i, clear_wm_i, en_i, load_i, down_i, delta_i, d_i, thresh_i,
    output q_o, max_o, min_o, wrap_o, wm_wrap_o, alarm_o
  );
endinterface

// File: rtl/multi_watermark_counter.sv
// Bank of independent up/down delta counters, each with high/low watermarks,
// sticky wrap/saturation flags and a sticky threshold alarm. All outputs are registered.
module multi_watermark_counter #(
  parameter int NUM_CHAN = 4,
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  multi_watermark_counter_if.slave     bus
);

  logic [NUM_CHAN-1:0][WIDTH-1:0] q_q, max_q, min_q, q_d;
  logic [NUM_CHAN-1:0][WIDTH:0]   arith;
  logic [NUM_CHAN-1:0]            wrap_q, wm_wrap_q, alarm_q;
  logic [NUM_CHAN-1:0]            oor, hit;

  // Next counter value; the extra arith bit is the carry (up) or borrow (down).
  always_comb begin
    q_d   = q_q;
    arith = '0;
    oor   = '0;
    hit   = '0;
    for (int c = 0; c < NUM_CHAN; c++) begin
      arith[c] = bus.down_i[c] ? ({1'b0, q_q[c]} - {1'b0, bus.delta_i[c]})
                               : ({1'b0, q_q[c]} + {1'b0, bus.delta_i[c]});
      if (bus.clr_i || bus.clear_i[c]) begin
        q_d[c] = '0;
      end else if (bus.load_i[c]) begin
        q_d[c] = bus.d_i[c];
      end else if (bus.en_i[c]) begin
        oor[c] = arith[c][WIDTH];
        if (arith[c][WIDTH] && SATURATE) begin
          q_d[c] = bus.down_i[c] ? '0 : '1;
        end else begin
          q_d[c] = arith[c][WIDTH-1:0];
        end
      end
      hit[c] = (q_d[c] >= bus.thresh_i);
    end
  end

  // Watermarks track q_d rather than q so max >= q >= min holds on every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q       <= '0;
      max_q     <= '0;
      min_q     <= '0;
      wrap_q    <= '0;
      wm_wrap_q <= '0;
      alarm_q   <= '0;
    end else begin
      for (int c = 0; c < NUM_CHAN; c++) begin
        q_q[c] <= q_d[c];
        if (bus.clr_i) begin
          max_q[c]     <= '0;
          min_q[c]     <= '0;
          wrap_q[c]    <= 1'b0;
          wm_wrap_q[c] <= 1'b0;
          alarm_q[c]   <= 1'b0;
        end else begin
          if (bus.clear_i[c] || bus.load_i[c]) begin
            wrap_q[c] <= 1'b0;
          end else if (oor[c]) begin
            wrap_q[c] <= 1'b1;
          end

          if (bus.clear_wm_i[c]) begin
            max_q[c]   <= q_d[c];
            min_q[c]   <= q_d[c];
            alarm_q[c] <= hit[c];
          end else begin
            if (q_d[c] > max_q[c]) max_q[c] <= q_d[c];
            if (q_d[c] < min_q[c]) min_q[c] <= q_d[c];
            if (hit[c]) alarm_q[c] <= 1'b1;
          end

          // A same-cycle out-of-range event beats the watermark re-arm.
          if (oor[c]) begin
            wm_wrap_q[c] <= 1'b1;
          end else if (bus.clear_wm_i[c]) begin
            wm_wrap_q[c] <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.q_o       = q_q;
  assign bus.max_o     = max_q;
  assign bus.min_o     = min_q;
  assign bus.wrap_o    = wrap_q;
  assign bus.wm_wrap_o = wm_wrap_q;
  assign bus.alarm_o   = alarm_q;

endmodule
